code_class_counter: RTL

- Downstream consumer of the 3-bit code stream produced by the testbench sequencer.
- Classifies each accepted code into one of four range classes using priority casez semantics, with an explicit catch-all so no code value goes unmatched.
- Keeps a saturating hit counter per class.
- On request, serializes the four counts over a valid/ready report port, then clears them.

---
 rtl/code_class_counter_if.sv | 26 ++
 rtl/code_class_counter.sv | 101 ++++++++++
 2 files changed

// File: rtl/code_class_counter_if.sv
// Code-in / report-out bundle for code_class_counter; the slave modport is the counter side.
interface code_class_counter_if #(parameter int CNT_W = 8);
  logic             in_valid;
  logic [2:0]       in_data;
  logic             in_ready;
  logic             clr;
  logic             rpt_req;
  logic             cls_valid;
  logic [1:0]       cls_id;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [1:0]       rpt_id;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_last;
  logic             busy;

  modport master (
    output in_valid, in_data, clr, rpt_req, rpt_ready,
    input  in_ready, cls_valid, cls_id, rpt_valid, rpt_id, rpt_count, rpt_last, busy
  );

  modport slave (
    input  in_valid, in_data, clr, rpt_req, rpt_ready,
    output in_ready, cls_valid, cls_id, rpt_valid, rpt_id, rpt_count, rpt_last, busy
  );
endinterface

// File: rtl/code_class_counter.sv
// Classifies 3-bit codes into four saturating per-class counters and reports them as 4 beats.
// cls_valid/cls_id one cycle after accept; in_ready drops for the whole report, beats stall on rpt_ready.
module code_class_counter #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  code_class_counter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, REPORT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                  state_q, state_d;
  logic [1:0]              beat_q, beat_d;
  logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic                    cls_valid_q, cls_valid_d;
  logic [1:0]              cls_id_q, cls_id_d;
  logic [1:0]              cls;
  logic                    accept;

  // Unknown bits are tested before the casez so X/Z never alias onto a real code.
  always_comb begin
    cls = 2'd3;
    if (!$isunknown(bus.in_data)) begin
      casez (bus.in_data)
        3'b00?:  cls = 2'd0;
        3'b01?:  cls = 2'd1;
        3'b1??:  cls = 2'd2;
        default: cls = 2'd3;
      endcase
    end
  end

  assign accept = bus.in_valid && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    cls_valid_d = accept;
    cls_id_d    = accept ? cls : cls_id_q;
    case (state_q)
      IDLE: begin
        if (accept && (cnt_q[cls] != CNT_MAX)) begin
          cnt_d[cls] = cnt_q[cls] + 1'b1;
        end
        // Clear overrides a same-cycle accept; a same-cycle report then sees zeros.
        if (bus.clr) begin
          cnt_d = '0;
        end
        if (bus.rpt_req) begin
          state_d = REPORT;
          beat_d  = 2'd0;
        end
      end
      REPORT: begin
        if (bus.rpt_ready) begin
          if (beat_q == 2'd3) begin
            state_d = IDLE;
            beat_d  = 2'd0;
            cnt_d   = '0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      cnt_q       <= '0;
      cls_valid_q <= 1'b0;
      cls_id_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      cls_valid_q <= cls_valid_d;
      cls_id_q    <= cls_id_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == REPORT);
  assign bus.rpt_valid = (state_q == REPORT);
  assign bus.rpt_id    = (state_q == REPORT) ? beat_q : 2'd0;
  assign bus.rpt_count = (state_q == REPORT) ? cnt_q[beat_q] : '0;
  assign bus.rpt_last  = (state_q == REPORT) && (beat_q == 2'd3);
  assign bus.cls_valid = cls_valid_q;
  assign bus.cls_id    = cls_id_q;

endmodule
